// File: rtl/w_sched_stream.sv
`default_nettype none
// ============================================================================
// Module   : w_sched_stream
// Brief    : SHA-2 message-schedule generator. Accepts one 16-word block on a
//            valid/ready input and streams W[0..ROUNDS-1] on a valid/ready
//            output, one word per accepted beat. 32-bit words cover
//            SHA-224/256, 64-bit words cover SHA-384/512.
// Revision : 1.0 - initial release
// ============================================================================
module w_sched_stream #(
  parameter int WORDSIZE = 32,
  parameter int ROUNDS   = 64,
  parameter int IDXW     = $clog2(ROUNDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [16*WORDSIZE-1:0]   blk_data,
  input  logic                     blk_valid,
  output logic                     blk_ready,
  output logic [WORDSIZE-1:0]      w_out,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic [IDXW-1:0]          w_idx,
  output logic                     w_last,
  output logic                     busy
);

  localparam logic [IDXW-1:0] c_LAST    = IDXW'(ROUNDS - 1);
  localparam logic [IDXW-1:0] c_PRELAST = IDXW'(ROUNDS - 2);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic [WORDSIZE-1:0] r_stack [16];   // slot 0 = oldest word (current W[t])
  logic [IDXW-1:0]     r_idx;
  logic                r_blk_ready;
  logic                r_w_valid;
  logic                r_w_last;
  logic                r_busy;

  logic [WORDSIZE-1:0] w_sig0_in;
  logic [WORDSIZE-1:0] w_sig1_in;
  logic [WORDSIZE-1:0] w_sig0;
  logic [WORDSIZE-1:0] w_sig1;
  logic [WORDSIZE-1:0] w_next;

  // Parameter legality: only the two standard SHA-2 word/round pairings exist.
  if (!((WORDSIZE == 32 && ROUNDS == 64) || (WORDSIZE == 64 && ROUNDS == 80))) begin : g_bad_param
    $error("w_sched_stream: WORDSIZE/ROUNDS must be 32/64 or 64/80");
  end

  // W[t-15] sits in slot 1 and W[t-2] in slot 14 when slot 0 holds W[t-16].
  assign w_sig0_in = r_stack[1];
  assign w_sig1_in = r_stack[14];

  // Small sigma functions for the selected word size.
  if (WORDSIZE == 32) begin : g_sig32
    assign w_sig0 = {w_sig0_in[6:0],  w_sig0_in[31:7]}
                  ^ {w_sig0_in[17:0], w_sig0_in[31:18]}
                  ^ (w_sig0_in >> 3);
    assign w_sig1 = {w_sig1_in[16:0], w_sig1_in[31:17]}
                  ^ {w_sig1_in[18:0], w_sig1_in[31:19]}
                  ^ (w_sig1_in >> 10);
  end else begin : g_sig64
    assign w_sig0 = {w_sig0_in[0],    w_sig0_in[63:1]}
                  ^ {w_sig0_in[7:0],  w_sig0_in[63:8]}
                  ^ (w_sig0_in >> 7);
    assign w_sig1 = {w_sig1_in[18:0], w_sig1_in[63:19]}
                  ^ {w_sig1_in[60:0], w_sig1_in[63:61]}
                  ^ (w_sig1_in >> 6);
  end

  // Next schedule word; additions wrap modulo 2^WORDSIZE by width.
  assign w_next = w_sig1 + r_stack[9] + w_sig0 + r_stack[0];

  // Control FSM, word stack and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_blk_ready <= 1'b1;
      r_w_valid   <= 1'b0;
      r_w_last    <= 1'b0;
      r_busy      <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        r_stack[k] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (blk_valid) begin
            for (int k = 0; k < 16; k++) begin
              r_stack[k] <= blk_data[(16-k)*WORDSIZE-1 -: WORDSIZE];
            end
            r_idx       <= '0;
            r_state     <= ST_RUN;
            r_blk_ready <= 1'b0;
            r_w_valid   <= 1'b1;
            r_w_last    <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_ready) begin
            if (r_idx == c_LAST) begin
              // Final word consumed: stack left as-is, always spend one IDLE cycle.
              r_idx       <= '0;
              r_state     <= ST_IDLE;
              r_blk_ready <= 1'b1;
              r_w_valid   <= 1'b0;
              r_w_last    <= 1'b0;
              r_busy      <= 1'b0;
            end else begin
              for (int k = 0; k < 15; k++) begin
                r_stack[k] <= r_stack[k+1];
              end
              r_stack[15] <= w_next;
              r_idx       <= r_idx + IDXW'(1);
              r_w_last    <= (r_idx == c_PRELAST);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign blk_ready = r_blk_ready;
  assign w_out     = r_stack[0];
  assign w_valid   = r_w_valid;
  assign w_idx     = r_idx;
  assign w_last    = r_w_last;
  assign busy      = r_busy;

endmodule
`default_nettype wire
